// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core pipeline hazard control.
package mips_pkg;

    typedef enum logic {
        RUN,
        MD_WAIT
    } hazard_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam int unsigned MD_LATENCY_DEFAULT = 32;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the ID/EX pipeline and the hazard controller.
interface hazard_ctrl_if;

    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rt;
    logic        id_uses_hilo;
    logic        id_ex_mem_read;
    logic [4:0]  id_ex_rt;
    logic        md_start;
    logic        branch_taken;
    logic        pc_write;
    logic        if_id_write;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        md_busy;
    logic        md_done;
    logic [31:0] stall_cycles;

    modport master (
        output id_rs, id_rt, id_uses_rt, id_uses_hilo, id_ex_mem_read, id_ex_rt,
               md_start, branch_taken,
        input  pc_write, if_id_write, if_id_flush, id_ex_flush, md_busy, md_done,
               stall_cycles
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, id_uses_hilo, id_ex_mem_read, id_ex_rt,
               md_start, branch_taken,
        output pc_write, if_id_write, if_id_flush, id_ex_flush, md_busy, md_done,
               stall_cycles
    );

endinterface

// File: rtl/md_busy_timer.sv
// Tracks HI/LO unit occupancy for a fixed-latency mult/div.
module md_busy_timer
    import mips_pkg::*;
#(
    parameter int unsigned MD_LATENCY = MD_LATENCY_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_md_start,
    output logic o_md_busy,
    output logic o_md_done
);

    localparam int unsigned     CNT_W    = $clog2(MD_LATENCY);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_LATENCY - 1);

    hazard_state_t    r_state;
    hazard_state_t    w_state_nxt;
    logic [CNT_W-1:0] r_md_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= RUN;
            r_md_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_md_cnt <= w_cnt_nxt;
        end
    end

    // A start seen while already waiting is dropped; the unit is single-issue.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_md_cnt;
        case (r_state)
            RUN: begin
                if (i_md_start) begin
                    w_state_nxt = MD_WAIT;
                    w_cnt_nxt   = CNT_LOAD;
                end
            end
            MD_WAIT: begin
                if (r_md_cnt != '0) begin
                    w_cnt_nxt = r_md_cnt - 1'b1;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            default: w_state_nxt = RUN;
        endcase
    end

    always_comb begin
        o_md_busy = (r_state == MD_WAIT);
        o_md_done = (r_state == MD_WAIT) && (r_md_cnt == '0);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use / branch / HI-LO hazard resolution for the 5-stage MIPS pipeline,
// with a count of cycles in which the PC was held.
module hazard_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned MD_LATENCY = MD_LATENCY_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    hazard_ctrl_if.slave  hz
);

    logic        w_md_busy;
    logic        w_md_done;
    logic        w_load_use;
    logic        w_hilo_stall;
    logic        w_pc_write;
    logic [31:0] r_stall_cycles;

    md_busy_timer #(
        .MD_LATENCY (MD_LATENCY)
    ) u_md_busy_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_md_start (hz.md_start),
        .o_md_busy  (w_md_busy),
        .o_md_done  (w_md_done)
    );

    always_comb begin
        w_load_use   = hz.id_ex_mem_read && (hz.id_ex_rt != REG_ZERO) &&
                       ((hz.id_ex_rt == hz.id_rs) ||
                        (hz.id_uses_rt && (hz.id_ex_rt == hz.id_rt)));
        w_hilo_stall = w_md_busy && hz.id_uses_hilo;
    end

    // A taken branch wins over stalls: the stalled ID instruction is wrong-path.
    always_comb begin
        w_pc_write     = 1'b1;
        hz.if_id_write = 1'b1;
        hz.if_id_flush = 1'b0;
        hz.id_ex_flush = 1'b0;
        if (hz.branch_taken) begin
            hz.if_id_flush = 1'b1;
            hz.id_ex_flush = 1'b1;
        end else if (w_load_use || w_hilo_stall) begin
            w_pc_write     = 1'b0;
            hz.if_id_write = 1'b0;
            hz.id_ex_flush = 1'b1;
        end
        hz.pc_write = w_pc_write;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
        end else if (!w_pc_write) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    always_comb begin
        hz.md_busy      = w_md_busy;
        hz.md_done      = w_md_done;
        hz.stall_cycles = r_stall_cycles;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl against a cycle-count reference model.
module tb_hazard_ctrl;

    localparam int unsigned LAT = 4;

    logic clk;
    logic rst_n;

    hazard_ctrl_if ifc ();

    hazard_ctrl #(
        .MD_LATENCY (LAT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Reference state: cycles of HI/LO occupancy remaining, and expected counter.
    int unsigned m_left  = 0;
    logic [31:0] m_stall = '0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        ifc.id_rs          = 5'd0;
        ifc.id_rt          = 5'd0;
        ifc.id_uses_rt     = 1'b0;
        ifc.id_uses_hilo   = 1'b0;
        ifc.id_ex_mem_read = 1'b0;
        ifc.id_ex_rt       = 5'd0;
        ifc.md_start       = 1'b0;
        ifc.branch_taken   = 1'b0;
    endtask

    // Compare every output to the model, then advance through one rising edge.
    task automatic step(input string tag);
        logic lu, hs, e_pc, e_ifw, e_iff, e_idf;
        #1;
        if (!rst_n) begin
            m_left  = 0;
            m_stall = '0;
        end
        lu = ifc.id_ex_mem_read && (ifc.id_ex_rt != 5'd0) &&
             ((ifc.id_ex_rt == ifc.id_rs) || (ifc.id_uses_rt && (ifc.id_ex_rt == ifc.id_rt)));
        hs = (m_left > 0) && ifc.id_uses_hilo;
        if (ifc.branch_taken) begin
            e_pc = 1; e_ifw = 1; e_iff = 1; e_idf = 1;
        end else if (lu || hs) begin
            e_pc = 0; e_ifw = 0; e_iff = 0; e_idf = 1;
        end else begin
            e_pc = 1; e_ifw = 1; e_iff = 0; e_idf = 0;
        end
        check_eq({tag, ".pc_write"},     32'(ifc.pc_write),    32'(e_pc));
        check_eq({tag, ".if_id_write"},  32'(ifc.if_id_write), 32'(e_ifw));
        check_eq({tag, ".if_id_flush"},  32'(ifc.if_id_flush), 32'(e_iff));
        check_eq({tag, ".id_ex_flush"},  32'(ifc.id_ex_flush), 32'(e_idf));
        check_eq({tag, ".md_busy"},      32'(ifc.md_busy),     32'(m_left > 0));
        check_eq({tag, ".md_done"},      32'(ifc.md_done),     32'(m_left == 1));
        check_eq({tag, ".stall_cycles"}, ifc.stall_cycles,     m_stall);
        @(posedge clk);
        if (rst_n) begin
            if (!e_pc) m_stall = m_stall + 32'd1;
            if (m_left > 0) m_left = m_left - 1;
            else if (ifc.md_start) m_left = LAT;
        end
        @(negedge clk);
    endtask

    task automatic set_load_use();
        clear_inputs();
        ifc.id_ex_mem_read = 1'b1;
        ifc.id_ex_rt       = 5'd8;
        ifc.id_rs          = 5'd8;
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check_eq("reset.md_busy",  32'(ifc.md_busy), 32'd0);
        check_eq("reset.md_done",  32'(ifc.md_done), 32'd0);
        check_eq("reset.stall",    ifc.stall_cycles, 32'd0);
        check_eq("reset.pc_write", 32'(ifc.pc_write), 32'd1);
        step("reset");
        rst_n = 1'b1;
        step("idle");

        // Load-use: one bubble, counter 0 -> 1
        set_load_use();
        #1;
        check_eq("lu.pc_write",    32'(ifc.pc_write),    32'd0);
        check_eq("lu.if_id_write", 32'(ifc.if_id_write), 32'd0);
        check_eq("lu.id_ex_flush", 32'(ifc.id_ex_flush), 32'd1);
        step("lu");
        clear_inputs();
        #1;
        check_eq("lu.count", ifc.stall_cycles, 32'd1);
        step("lu_after");

        // Load to $zero never stalls
        clear_inputs();
        ifc.id_ex_mem_read = 1'b1;
        #1;
        check_eq("zero.pc_write", 32'(ifc.pc_write), 32'd1);
        step("zero");

        // Branch overrides load-use; counter unchanged
        set_load_use();
        ifc.branch_taken = 1'b1;
        #1;
        check_eq("br.pc_write",    32'(ifc.pc_write),    32'd1);
        check_eq("br.if_id_flush", 32'(ifc.if_id_flush), 32'd1);
        check_eq("br.id_ex_flush", 32'(ifc.id_ex_flush), 32'd1);
        step("br");
        clear_inputs();
        #1;
        check_eq("br.count", ifc.stall_cycles, 32'd1);

        // Mult then mflo held in ID
        ifc.md_start = 1'b1;
        step("mult_issue");
        clear_inputs();
        ifc.id_uses_hilo = 1'b1;
        for (int k = 1; k <= int'(LAT); k++) begin
            #1;
            check_eq($sformatf("mflo.busy%0d", k),  32'(ifc.md_busy),  32'd1);
            check_eq($sformatf("mflo.done%0d", k),  32'(ifc.md_done),  32'(k == int'(LAT)));
            check_eq($sformatf("mflo.stall%0d", k), 32'(ifc.pc_write), 32'd0);
            step("mflo");
        end
        #1;
        check_eq("mflo.release", 32'(ifc.pc_write), 32'd1);
        check_eq("mflo.idle",    32'(ifc.md_busy),  32'd1 - 32'd1);
        step("mflo_rel");

        // Mult then unrelated addu: never stalled
        clear_inputs();
        ifc.md_start = 1'b1;
        step("mult2_issue");
        clear_inputs();
        ifc.id_rs = 5'd3;
        ifc.id_rt = 5'd4;
        ifc.id_uses_rt = 1'b1;
        for (int k = 1; k <= int'(LAT); k++) begin
            #1;
            check_eq($sformatf("addu.pc%0d", k), 32'(ifc.pc_write), 32'd1);
            step("addu");
        end

        // Asynchronous reset in the middle of a mult
        clear_inputs();
        ifc.md_start = 1'b1;
        step("mult3_issue");
        clear_inputs();
        step("mult3_c1");
        rst_n = 1'b0;
        #1;
        check_eq("rstmid.md_busy", 32'(ifc.md_busy), 32'd0);
        check_eq("rstmid.md_done", 32'(ifc.md_done), 32'd0);
        check_eq("rstmid.stall",   ifc.stall_cycles, 32'd0);
        step("rstmid");
        rst_n = 1'b1;
        step("rstmid_rel");

        // Counter wrap
        force dut.r_stall_cycles = 32'hFFFF_FFFF;
        #1;
        release dut.r_stall_cycles;
        m_stall = 32'hFFFF_FFFF;
        set_load_use();
        step("wrap");
        clear_inputs();
        #1;
        check_eq("wrap.count", ifc.stall_cycles, 32'd0);
        step("wrap_after");

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            rst_n              = ($urandom_range(0, 63) != 0);
            ifc.id_rs          = 5'($urandom_range(0, 3));
            ifc.id_rt          = 5'($urandom_range(0, 3));
            ifc.id_uses_rt     = 1'($urandom_range(0, 1));
            ifc.id_uses_hilo   = 1'($urandom_range(0, 1));
            ifc.id_ex_mem_read = 1'($urandom_range(0, 1));
            ifc.id_ex_rt       = 5'($urandom_range(0, 3));
            ifc.md_start       = ($urandom_range(0, 5) == 0);
            ifc.branch_taken   = ($urandom_range(0, 7) == 0);
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
